// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEY_W = 4;

  localparam logic [COLS-1:0] COL_RESET = 4'b1110;
  localparam logic [ROWS-1:0] ROW_IDLE  = 4'b1111;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    HELD
  } state_e;

  // Index of the lowest low bit; ties resolve to the lowest row/column.
  function automatic logic [1:0] lowest_zero(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Pin and key-event bundle between the keypad matrix, the scanner and its consumer.
interface keypad_if;
  import keypad_pkg::*;

  logic [ROWS-1:0]  row;
  logic [COLS-1:0]  col;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs, reset to a chosen idle value.
module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad decoder with debounced press/release and a one-cycle key strobe.
// Define KEYPAD_REPEAT_EN to enable auto-repeat strobes while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 25
`endif
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_CNT + 1);
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
`endif

  logic [ROWS-1:0]   rowSync;
  logic [SLOT_W-1:0] slotCnt_q, slotCnt_d;
  logic              slotEnd;
  state_e            state_q;
  logic [COLS-1:0]   col_q, colNext;
  logic [ROWS-1:0]   pattern_q;
  logic [CNT_W-1:0]  matchCnt_q;
  logic [CNT_W-1:0]  relCnt_q;
  logic [KEY_W-1:0]  keyCode_q, acceptCode;
  logic              keyValid_q;
  logic              keyHeld_q;
  logic              rowActive;
  logic              acceptNow;
`ifdef KEYPAD_REPEAT_EN
  logic [REP_W-1:0]  repCnt_q;
  logic              repArmed_q;
`endif

  sync_2ff #(
    .WIDTH    (ROWS),
    .RESET_VAL(ROW_IDLE)
  ) uRowSync (
    .clk(clk),
    .rst(rst),
    .d_i(kp.row),
    .q_o(rowSync)
  );

  always_comb begin
    slotEnd    = (slotCnt_q == SLOT_W'(SCAN_DIV - 1));
    slotCnt_d  = slotEnd ? '0 : slotCnt_q + 1'b1;
    colNext    = {col_q[COLS-2:0], col_q[COLS-1]};
    rowActive  = (rowSync != ROW_IDLE);
    acceptCode = {lowest_zero(rowSync), lowest_zero(col_q)};
    acceptNow  = 1'b0;
    if (slotEnd) begin
      if (state_q == SCAN && rowActive && DEBOUNCE_CNT == 1)
        acceptNow = 1'b1;
      if (state_q == CONFIRM && rowSync == pattern_q &&
          matchCnt_q + 1'b1 == CNT_W'(DEBOUNCE_CNT))
        acceptNow = 1'b1;
    end
  end

  // Everything advances only at slot ends; the accept block below overrides the case arms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slotCnt_q  <= '0;
      state_q    <= SCAN;
      col_q      <= COL_RESET;
      pattern_q  <= ROW_IDLE;
      matchCnt_q <= '0;
      relCnt_q   <= '0;
      keyCode_q  <= '0;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      repCnt_q   <= '0;
      repArmed_q <= 1'b0;
`endif
    end else begin
      slotCnt_q  <= slotCnt_d;
      keyValid_q <= 1'b0;
      if (slotEnd) begin
        unique case (state_q)
          SCAN: begin
            if (rowActive) begin
              pattern_q  <= rowSync;
              matchCnt_q <= CNT_W'(1);
              state_q    <= CONFIRM;
            end else begin
              col_q <= colNext;
            end
          end
          CONFIRM: begin
            if (rowSync == pattern_q) begin
              matchCnt_q <= matchCnt_q + 1'b1;
            end else begin
              state_q <= SCAN;
              col_q   <= colNext;
            end
          end
          HELD: begin
            if (!rowActive) begin
`ifdef KEYPAD_REPEAT_EN
              repCnt_q   <= '0;
              repArmed_q <= 1'b0;
`endif
              if (relCnt_q + 1'b1 == CNT_W'(DEBOUNCE_CNT)) begin
                relCnt_q  <= '0;
                keyHeld_q <= 1'b0;
                state_q   <= SCAN;
                col_q     <= colNext;
              end else begin
                relCnt_q <= relCnt_q + 1'b1;
              end
            end else begin
              relCnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
              // First strobe after REPEAT_DELAY slots, then every REPEAT_PERIOD slots.
              if (repCnt_q + 1'b1 == (repArmed_q ? REP_W'(REPEAT_PERIOD)
                                                 : REP_W'(REPEAT_DELAY))) begin
                keyValid_q <= 1'b1;
                repCnt_q   <= '0;
                repArmed_q <= 1'b1;
              end else begin
                repCnt_q <= repCnt_q + 1'b1;
              end
`endif
            end
          end
          default: state_q <= SCAN;
        endcase

        if (acceptNow) begin
          state_q    <= HELD;
          keyCode_q  <= acceptCode;
          keyValid_q <= 1'b1;
          keyHeld_q  <= 1'b1;
          relCnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
          repCnt_q   <= '0;
          repArmed_q <= 1'b0;
`endif
        end
      end
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = keyCode_q;
  assign kp.key_valid = keyValid_q;
  assign kp.key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed slot table, reset corner cases and
// randomized key activity against a slot-level reference model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
`ifdef KEYPAD_REPEAT_EN
  localparam int RD = 2;
  localparam int RP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0]  rowDrive;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  keypad_if kpIf ();

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEB)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kpIf)
  );

  // Physical matrix: a row reads low when a pressed key sits in a column driven low.
  always_comb begin
    rowDrive = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kpIf.col[c]) rowDrive[r] = 1'b0;
  end
  assign kpIf.row = rowDrive;

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  col;
    logic        valid;
    logic [3:0]  code;
    logic        held;
  } vec_t;

  vec_t vecs[$];

  // Reference model state, one step per scan slot
  int mCol, mPhase, mLatched, mStreak, mRel, mCode, mHeld, mDownSlots;
  bit mValid;

  task automatic cmp4(input string name, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] eCol, input logic eValid,
                             input logic [3:0] eCode, input logic eHeld);
    cmp4({tag, ".col"}, kpIf.col, eCol);
    cmp1({tag, ".valid"}, kpIf.key_valid, eValid);
    cmp4({tag, ".code"}, kpIf.key_code, eCode);
    cmp1({tag, ".held"}, kpIf.key_held, eHeld);
  endtask

  // Holds a key mask for one slot; returns #1 after the slot-ending edge.
  task automatic applyStimulus(input logic [15:0] mask, input logic [3:0] colNow);
    pressed = mask;
    for (int k = 0; k < SCAN_DIV; k++) begin
      @(posedge clk);
      #1;
      if (k < SCAN_DIV - 1) begin
        cmp1("midSlotValid", kpIf.key_valid, 1'b0);
        cmp4("midSlotCol", kpIf.col, colNow);
      end
    end
  endtask

  task automatic modelReset();
    mCol = 0; mPhase = 0; mLatched = 0; mStreak = 0; mRel = 0;
    mCode = 0; mHeld = 0; mDownSlots = 0; mValid = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset", COL_RESET, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  function automatic logic [3:0] colOf(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic modelAccept(input int pr);
    int rowIdx;
    rowIdx = 0;
    for (int r = 3; r >= 0; r--) if (pr[r]) rowIdx = r;
    mCode = rowIdx * 4 + mCol;
    mValid = 1'b1;
    mHeld = 1;
    mPhase = 2;
    mRel = 0;
    mDownSlots = 0;
  endtask

  // Spec rules applied to the rows pressed in the current column during one slot.
  task automatic modelSlot(input logic [15:0] mask);
    int pr;
    pr = 0;
    for (int r = 0; r < 4; r++) if (mask[r*4+mCol]) pr |= (1 << r);
    mValid = 1'b0;
    if (mPhase == 0) begin
      if (pr != 0) begin
        mLatched = pr;
        mStreak = 1;
        if (mStreak >= DEB) modelAccept(pr);
        else mPhase = 1;
      end else begin
        mCol = (mCol + 1) % 4;
      end
    end else if (mPhase == 1) begin
      if (pr == mLatched) begin
        mStreak++;
        if (mStreak >= DEB) modelAccept(pr);
      end else begin
        mPhase = 0;
        mCol = (mCol + 1) % 4;
      end
    end else begin
      if (pr == 0) begin
        mRel++;
        mDownSlots = 0;
        if (mRel >= DEB) begin
          mHeld = 0;
          mPhase = 0;
          mRel = 0;
          mCol = (mCol + 1) % 4;
        end
      end else begin
        mRel = 0;
        mDownSlots++;
`ifdef KEYPAD_REPEAT_EN
        if (mDownSlots >= RD && (mDownSlots - RD) % RP == 0) mValid = 1'b1;
`endif
      end
    end
  endtask

  task automatic addVec(input logic [15:0] m, input logic [3:0] c, input logic v,
                        input logic [3:0] k, input logic h);
    vec_t e;
    e.mask = m; e.col = c; e.valid = v; e.code = k; e.held = h;
    vecs.push_back(e);
  endtask

  initial begin
    logic [3:0]  curCol;
    logic [15:0] mask;
    logic        expRep;

    // Idle scan, row2/col1 press+release with a key in another column ignored,
    // two rows in column 0, a bounce, then a stable press in column 1.
    addVec(16'h0000, 4'b1101, 0, 4'h0, 0);
    addVec(16'h0000, 4'b1011, 0, 4'h0, 0);
    addVec(16'h0000, 4'b0111, 0, 4'h0, 0);
    addVec(16'h0000, 4'b1110, 0, 4'h0, 0);
    addVec(16'h0200, 4'b1101, 0, 4'h0, 0);
    addVec(16'h0200, 4'b1101, 0, 4'h0, 0);
    addVec(16'h0200, 4'b1101, 0, 4'h0, 0);
    addVec(16'h0200, 4'b1101, 1, 4'h9, 1);
    addVec(16'h0208, 4'b1101, 0, 4'h9, 1);
    addVec(16'h0000, 4'b1101, 0, 4'h9, 1);
    addVec(16'h0000, 4'b1101, 0, 4'h9, 1);
    addVec(16'h0000, 4'b1011, 0, 4'h9, 0);
    addVec(16'h0000, 4'b0111, 0, 4'h9, 0);
    addVec(16'h1010, 4'b1110, 0, 4'h9, 0);
    addVec(16'h1010, 4'b1110, 0, 4'h9, 0);
    addVec(16'h1010, 4'b1110, 0, 4'h9, 0);
    addVec(16'h1010, 4'b1110, 1, 4'h4, 1);
    addVec(16'h0000, 4'b1110, 0, 4'h4, 1);
    addVec(16'h0000, 4'b1110, 0, 4'h4, 1);
    addVec(16'h0000, 4'b1101, 0, 4'h4, 0);
    addVec(16'h0002, 4'b1101, 0, 4'h4, 0);
    addVec(16'h0000, 4'b1011, 0, 4'h4, 0);
    addVec(16'h0002, 4'b0111, 0, 4'h4, 0);
    addVec(16'h0000, 4'b1110, 0, 4'h4, 0);
    addVec(16'h0000, 4'b1101, 0, 4'h4, 0);
    addVec(16'h0002, 4'b1101, 0, 4'h4, 0);
    addVec(16'h0002, 4'b1101, 0, 4'h4, 0);
    addVec(16'h0002, 4'b1101, 1, 4'h1, 1);
    addVec(16'h0000, 4'b1101, 0, 4'h1, 1);
    addVec(16'h0000, 4'b1101, 0, 4'h1, 1);
    addVec(16'h0000, 4'b1011, 0, 4'h1, 0);

    applyReset();
    curCol = COL_RESET;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].mask, curCol);
      checkOutput($sformatf("vec%0d", i), vecs[i].col, vecs[i].valid, vecs[i].code,
                  vecs[i].held);
      curCol = vecs[i].col;
    end

    // Reset during debounce: a fresh full debounce is needed afterwards
    applyReset();
    applyStimulus(16'h1000, 4'b1110);
    applyStimulus(16'h1000, 4'b1110);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("rstConfirm", COL_RESET, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h1000, 4'b1110);
    checkOutput("postRst1", 4'b1110, 1'b0, 4'h0, 1'b0);
    applyStimulus(16'h1000, 4'b1110);
    checkOutput("postRst2", 4'b1110, 1'b0, 4'h0, 1'b0);
    applyStimulus(16'h1000, 4'b1110);
    checkOutput("postRst3", 4'b1110, 1'b1, 4'hC, 1'b1);

    // Reset inside the strobe cycle, then no late strobe once released
    #1 rst = 1'b1;
    #1 checkOutput("rstStrobe", COL_RESET, 1'b0, 4'h0, 1'b0);
    pressed = '0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h0000, 4'b1110);
    checkOutput("quiet1", 4'b1101, 1'b0, 4'h0, 1'b0);
    applyStimulus(16'h0000, 4'b1101);
    checkOutput("quiet2", 4'b1011, 1'b0, 4'h0, 1'b0);
    applyStimulus(16'h0000, 4'b1011);
    checkOutput("quiet3", 4'b0111, 1'b0, 4'h0, 1'b0);

    // Long hold after accept: auto-repeat strobes only when the feature is built in
    applyReset();
    for (int s = 0; s < DEB; s++) applyStimulus(16'h1000, 4'b1110);
    checkOutput("holdAccept", 4'b1110, 1'b1, 4'hC, 1'b1);
    for (int n = 1; n <= 6; n++) begin
      applyStimulus(16'h1000, 4'b1110);
`ifdef KEYPAD_REPEAT_EN
      expRep = (n >= RD) && ((n - RD) % RP == 0);
`else
      expRep = 1'b0;
`endif
      checkOutput($sformatf("hold+%0d", n), 4'b1110, expRep, 4'hC, 1'b1);
    end
    for (int s = 0; s < DEB; s++) applyStimulus(16'h0000, 4'b1110);
    checkOutput("holdRelease", 4'b1101, 1'b0, 4'hC, 1'b0);

    // Randomized key activity against the reference model
    applyReset();
    mask = '0;
    for (int s = 0; s < 400; s++) begin
      int pick;
      pick = $urandom_range(0, 9);
      if (pick == 6 || pick == 7) mask = '0;
      else if (pick == 8) mask = 16'(1) << $urandom_range(0, 15);
      else if (pick == 9) mask = (16'(1) << $urandom_range(0, 15)) |
                                 (16'(1) << $urandom_range(0, 15));
      curCol = colOf(mCol);
      applyStimulus(mask, curCol);
      modelSlot(mask);
      checkOutput($sformatf("rand%0d", s), colOf(mCol), mValid, 4'(mCode), mHeld != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
